// File: rtl/usbfs_endp_tx_pkt.sv
// -----------------------------------------------------------------------------
// usbfs_endp_tx_pkt
//
// Device-to-host bulk IN endpoint packetiser. Bytes from a valid/ready stream
// are packed into a fill buffer. Complete packets are handed to usbfsTxn's et*
// port through a separate held (presented) buffer. Because the held buffer is
// separate, one packet can be presented while the next one fills. A partial
// packet is sent when the stream has been idle for FLUSH_CYCLES cycles, or
// when i_flush is pulsed.
//
// Parameters
//   MAX_PKT       wMaxPacketSize in bytes (8, 16, 32 or 64).
//   FLUSH_CYCLES  idle cycles before a partial packet is sent (>= 1).
//
// Ports
//   i_clk            48 MHz clock, the single clock domain.
//   i_rst            synchronous active-high reset.
//   o_ready          byte-stream ready.
//   i_valid          byte-stream valid.
//   i_data           byte-stream data.
//   i_flush          pulse: send the partial packet now.
//   o_etStall        endpoint stall, tied to 0.
//   i_etReady        usbfsTxn has taken the presented packet.
//   o_etValid        a packet is presented.
//   o_etData         packet bytes; byte k sits at [8k+:8], unused bytes are 0.
//   o_etData_nBytes  packet length, 0..MAX_PKT.
//
// Optional feature (macro USBFS_TX_ZLP_EN)
//   When defined, a full-size packet that the host accepts arms a
//   zero-length packet (ZLP). The ZLP is sent if the fill buffer then stays
//   empty until the idle timeout, or if i_flush arrives first. The ZLP
//   terminates the host transfer.
// -----------------------------------------------------------------------------
module usbfs_endp_tx_pkt #(
   parameter int MAX_PKT      = 8,
   parameter int FLUSH_CYCLES = 48000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   output logic                       o_ready,
   input  logic                       i_valid,
   input  logic [7:0]                 i_data,
   input  logic                       i_flush,
   output logic                       o_etStall,
   input  logic                       i_etReady,
   output logic                       o_etValid,
   output logic [8*MAX_PKT-1:0]       o_etData,
   output logic [$clog2(MAX_PKT):0]   o_etData_nBytes
);

   localparam int CW = $clog2(MAX_PKT) + 1;        // count width, holds MAX_PKT
   localparam int AW = $clog2(MAX_PKT);            // fill buffer address width
   localparam int TW = $clog2(FLUSH_CYCLES + 1);   // timer width, holds FLUSH_CYCLES

   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PKT);
   localparam logic [TW-1:0] TMR_MAX  = TW'(FLUSH_CYCLES);

   // Fill buffer and stream-side state
   logic [7:0]           fill_q [MAX_PKT];
   logic [CW-1:0]        count_q, count_d;
   logic [TW-1:0]        timer_q, timer_d;

   // Held (presented) buffer
   logic                 valid_q;
   logic [8*MAX_PKT-1:0] data_q;
   logic [CW-1:0]        nbytes_q;

   // Decode
   logic                 accept;
   logic                 held_free;
   logic                 taken;
   logic                 expired;
   logic                 trig;
   logic                 zlp_run;
   logic                 zlp_trig;
   logic                 swap;
   logic [AW-1:0]        wr_idx;
   logic [8*MAX_PKT-1:0] pkt_d;

   assign o_ready   = !i_rst && (count_q < FULL_CNT);
   assign accept    = i_valid && o_ready;
   assign held_free = !valid_q || i_etReady;
   assign taken     = valid_q && i_etReady;
   assign expired   = (timer_q == TMR_MAX);

   assign trig = (count_q == FULL_CNT)
              || (expired && (count_q != '0))
              || (i_flush && (count_q != '0));

`ifdef USBFS_TX_ZLP_EN
   logic last_full_q;

   // A ZLP is armed only while nothing is filling and nothing is presented.
   assign zlp_run  = last_full_q && (count_q == '0) && !valid_q;
   assign zlp_trig = zlp_run && (expired || i_flush);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_full_q <= 1'b0;
      end else if (taken) begin
         last_full_q <= (nbytes_q == FULL_CNT);
      end
   end
`else
   assign zlp_run  = 1'b0;
   assign zlp_trig = 1'b0;
`endif

   assign swap = held_free && (trig || zlp_trig);

   // A byte accepted on the swap cycle starts the freshly emptied buffer.
   assign wr_idx = swap ? '0 : count_q[AW-1:0];

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block can leave a value unassigned and infer a latch.
      count_d = count_q;
      timer_d = timer_q;

      if (swap) begin
         count_d = accept ? CW'(1) : '0;
      end else if (accept) begin
         count_d = count_q + CW'(1);
      end

      // The timer saturates rather than wraps, so a held-off timeout stays
      // pending until the held buffer frees up.
      if (swap || accept) begin
         timer_d = '0;
      end else if (((count_q != '0) || zlp_run) && !expired) begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Mask the stale bytes above count. The held packet then shows zeros in
   // its unused bytes, and a ZLP is all zeros.
   always_comb begin
      pkt_d = '0;
      for (int k = 0; k < MAX_PKT; k++) begin
         if (CW'(k) < count_q) begin
            pkt_d[8*k +: 8] = fill_q[k];
         end
      end
   end

   // NOTE: the fill buffer has no reset. Bytes at or above count are never
   // presented, so clearing count alone discards a partial packet.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         fill_q[wr_idx] <= i_data;
      end
   end

   // NOTE: all state updates are non-blocking, so every register sees the
   // previous cycle's values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q  <= '0;
         timer_q  <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         nbytes_q <= '0;
      end else begin
         count_q <= count_d;
         timer_q <= timer_d;
         if (swap) begin
            valid_q  <= 1'b1;
            data_q   <= pkt_d;
            nbytes_q <= count_q;
         end else if (taken) begin
            valid_q  <= 1'b0;
         end
      end
   end

   assign o_etStall       = 1'b0;
   assign o_etValid       = valid_q;
   assign o_etData        = data_q;
   assign o_etData_nBytes = nbytes_q;

endmodule
